// File: rtl/aes_result_reader.sv
// aes_result_reader
//   Readout engine on the data-memory side of the SIMD AES pipeline. It snoops
//   MEM-stage stores for a write to the DONE mailbox, stalls the core, reads
//   NUM_WORDS words starting at BASE_ADDR through the data-memory read port and
//   streams them to the host over valid/ready with a last-word marker.
//
//   Optional build macro: AES_READER_BYTESWAP_EN
//     defined   - each captured word is byte-reversed ({b0,b1,b2,b3}) so the
//                 host receives the AES state in FIPS-197 byte order
//     undefined - mem_rdata is passed through unmodified
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   snoop_we/addr       MEM-stage MemWrite and word address
//   mem_rd_en/addr      data-memory read request (data returns next cycle)
//   mem_rdata           data-memory read data
//   cpu_stall           holds PC and IF/ID while a readout is in progress
//   out_valid/ready     host stream handshake
//   out_data/out_last   stream word and final-word marker
//   done                one-cycle pulse after the final handshake
//   overrun             sticky: trigger seen while busy
//   overrun_clr         clears overrun (a coincident trigger while busy wins)
module aes_result_reader #(
  parameter int unsigned       ADDR_W    = 12,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h100,
  parameter int unsigned       NUM_WORDS = 4,
  parameter logic [ADDR_W-1:0] DONE_ADDR = 12'h0FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int unsigned      IDX_W    = $clog2(NUM_WORDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND,
    FIN
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] capture_word;
  logic              trigger;

  assign trigger = snoop_we && (snoop_addr == DONE_ADDR);

  always_comb begin
    capture_word = mem_rdata;
`ifdef AES_READER_BYTESWAP_EN
    for (int unsigned b = 0; b < DATA_W / 8; b++) begin
      capture_word[8*b +: 8] = mem_rdata[DATA_W-8-8*b +: 8];
    end
`endif
  end

  // All handshake/stall outputs decode from state_q only, so they fall with the
  // asynchronous reset and out_valid never looks at out_ready.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    cpu_stall  = 1'b1;
    out_valid  = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        cpu_stall = 1'b0;
        if (trigger) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        // Sum is ADDR_W wide, so running past the top of memory wraps to 0.
        mem_addr  = BASE_ADDR + ADDR_W'(idx_q);
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        out_data_d = capture_word;
        out_last_d = (idx_q == LAST_IDX);
        state_d    = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_last_q) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = FETCH;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        cpu_stall = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (trigger && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign overrun  = overrun_q;

endmodule
